// File: rtl/segre_store_buffer.sv
// segre_store_buffer: circular store buffer sitting in front of the data cache.
// Stores are queued at the tail and the head entry drains into the cache
// whenever its write port is free. Loads look up the buffered stores
// combinationally. The youngest store that overlaps a load either forwards
// its data or reports a conflict.
// Build option: define SEGRE_SB_FORWARD_EN to enable store-to-load
// forwarding. When it is undefined, every overlap is reported as a conflict.

package segre_sb_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } memop_data_type_e;

    // Access size in bytes for each memory operation type
    function automatic logic [2:0] type_size(input memop_data_type_e t);
        case (t)
            BYTE:    return 3'd1;
            HALF:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

module segre_store_buffer
    import segre_sb_pkg::*;
#(
    parameter int SB_DEPTH  = 4,
    parameter int ADDR_SIZE = 32,
    parameter int WORD_SIZE = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    // store push
    input  logic                 st_valid_i,
    input  logic [ADDR_SIZE-1:0] st_addr_i,
    input  logic [WORD_SIZE-1:0] st_data_i,
    input  memop_data_type_e     st_type_i,
    // load lookup
    input  logic                 ld_valid_i,
    input  logic [ADDR_SIZE-1:0] ld_addr_i,
    input  memop_data_type_e     ld_type_i,
    // cache write port availability
    input  logic                 cache_free_i,
    // forwarding result
    output logic                 sb_hit_o,
    output logic [WORD_SIZE-1:0] sb_data_load_o,
    output logic                 sb_conflict_o,
    // head entry drain
    output logic                 sb_flush_o,
    output logic [ADDR_SIZE-1:0] sb_addr_o,
    output logic [WORD_SIZE-1:0] sb_data_flush_o,
    output memop_data_type_e     sb_type_flush_o,
    // occupancy
    output logic                 sb_full_o,
    output logic                 sb_empty_o
);

    localparam int PTR_W = $clog2(SB_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int OFF_W = $clog2(WORD_SIZE / 8);

    // Entry storage: only the valid bits carry reset, the payload is gated by them
    logic [SB_DEPTH-1:0]  ent_valid;
    logic [ADDR_SIZE-1:0] ent_addr [SB_DEPTH];
    logic [WORD_SIZE-1:0] ent_data [SB_DEPTH];
    memop_data_type_e     ent_type [SB_DEPTH];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic empty;
    logic full;
    logic pop;
    logic push;

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(SB_DEPTH));

    // A full buffer still accepts a store when the head drains on the same edge
    assign pop  = cache_free_i && !empty;
    assign push = st_valid_i && (!full || pop);

    assign sb_full_o  = full;
    assign sb_empty_o = empty;
    assign sb_flush_o = pop;

    // The head payload is forced to zero while empty so that reset shows clean outputs
    assign sb_addr_o       = empty ? '0   : ent_addr[head];
    assign sb_data_flush_o = empty ? '0   : ent_data[head];
    assign sb_type_flush_o = empty ? BYTE : ent_type[head];

    // Pointer, count and valid-bit state
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            ent_valid <= '0;
        end else begin
            // pop is applied before push so a full push+pop refills the head slot as valid
            if (pop) begin
                ent_valid[head] <= 1'b0;
                head            <= head + 1'b1;
            end
            if (push) begin
                ent_valid[tail] <= 1'b1;
                tail            <= tail + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry payload write at the tail
    // NOTE: the payload array has no reset; it is only ever observed through a set valid bit.
    always_ff @(posedge clk_i) begin
        if (push) begin
            ent_addr[tail] <= st_addr_i;
            ent_data[tail] <= st_data_i;
            ent_type[tail] <= st_type_i;
        end
    end

    // Lookup scratch signals
    logic [PTR_W-1:0]   idx;
    logic [ADDR_SIZE:0] ld_end;
    logic [ADDR_SIZE:0] ent_end;
    logic               ent_overlap;
    logic               found;
`ifdef SEGRE_SB_FORWARD_EN
    logic               ent_cover;
    logic [OFF_W-1:0]   ent_off;
    logic               best_cover;
    logic [WORD_SIZE-1:0] best_data;
`endif

    // Youngest-overlap search: walk oldest to youngest so the last match wins
    // NOTE: every signal gets a default first so the combinational block cannot infer a latch.
    always_comb begin
        idx         = head;
        ld_end      = {1'b0, ld_addr_i} + (ADDR_SIZE+1)'(type_size(ld_type_i));
        ent_end     = '0;
        ent_overlap = 1'b0;
        found       = 1'b0;
`ifdef SEGRE_SB_FORWARD_EN
        ent_cover   = 1'b0;
        ent_off     = '0;
        best_cover  = 1'b0;
        best_data   = '0;
`endif
        for (int i = 0; i < SB_DEPTH; i++) begin
            idx         = head + PTR_W'(i);
            ent_end     = {1'b0, ent_addr[idx]} + (ADDR_SIZE+1)'(type_size(ent_type[idx]));
            ent_overlap = ent_valid[idx] &&
                          ({1'b0, ent_addr[idx]} < ld_end) &&
                          ({1'b0, ld_addr_i} < ent_end);
            if (ent_overlap) begin
                found = 1'b1;
`ifdef SEGRE_SB_FORWARD_EN
                ent_cover  = (ent_addr[idx] <= ld_addr_i) && (ld_end <= ent_end);
                ent_off    = ld_addr_i[OFF_W-1:0] - ent_addr[idx][OFF_W-1:0];
                best_cover = ent_cover;
                best_data  = ent_data[idx] >> {ent_off, 3'b000};
`endif
            end
        end
    end

    // Forwarding decision from the youngest overlapping entry
    always_comb begin
        sb_hit_o       = 1'b0;
        sb_conflict_o  = 1'b0;
        sb_data_load_o = '0;
        if (ld_valid_i && found) begin
`ifdef SEGRE_SB_FORWARD_EN
            if (best_cover) begin
                sb_hit_o       = 1'b1;
                sb_data_load_o = best_data;
            end else begin
                sb_conflict_o  = 1'b1;
            end
`else
            sb_conflict_o = 1'b1;
`endif
        end
    end

endmodule

// File: tb/tb_segre_store_buffer.sv
// Directed self-checking bench for segre_store_buffer (SB_DEPTH=4).
// Expected forwarding results adapt to whether SEGRE_SB_FORWARD_EN is defined.

module tb_segre_store_buffer;
    import segre_sb_pkg::*;

`ifdef SEGRE_SB_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic             st_valid;
    logic [31:0]      st_addr;
    logic [31:0]      st_data;
    memop_data_type_e st_type;
    logic             ld_valid;
    logic [31:0]      ld_addr;
    memop_data_type_e ld_type;
    logic             cache_free;
    logic             sb_hit;
    logic [31:0]      sb_data_load;
    logic             sb_conflict;
    logic             sb_flush;
    logic [31:0]      sb_addr;
    logic [31:0]      sb_data_flush;
    memop_data_type_e sb_type_flush;
    logic             sb_full;
    logic             sb_empty;

    int checks = 0;
    int errors = 0;

    segre_store_buffer #(.SB_DEPTH(4), .ADDR_SIZE(32), .WORD_SIZE(32)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .st_valid_i      (st_valid),
        .st_addr_i       (st_addr),
        .st_data_i       (st_data),
        .st_type_i       (st_type),
        .ld_valid_i      (ld_valid),
        .ld_addr_i       (ld_addr),
        .ld_type_i       (ld_type),
        .cache_free_i    (cache_free),
        .sb_hit_o        (sb_hit),
        .sb_data_load_o  (sb_data_load),
        .sb_conflict_o   (sb_conflict),
        .sb_flush_o      (sb_flush),
        .sb_addr_o       (sb_addr),
        .sb_data_flush_o (sb_data_flush),
        .sb_type_flush_o (sb_type_flush),
        .sb_full_o       (sb_full),
        .sb_empty_o      (sb_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ld(input string tag, input logic hit, input logic conf, input logic [31:0] data);
        check({tag, " hit"}, 32'(sb_hit), 32'(hit));
        check({tag, " conflict"}, 32'(sb_conflict), 32'(conf));
        check({tag, " data"}, sb_data_load, data);
        check({tag, " exclusive"}, 32'(sb_hit & sb_conflict), 32'd0);
    endtask

    // Result for a load fully covered by the youngest overlapping store
    task automatic expect_fwd(input string tag, input logic [31:0] data);
        check_ld(tag, FWD, !FWD, FWD ? data : 32'd0);
    endtask

    task automatic load(input logic [31:0] a, input memop_data_type_e t);
        ld_valid = 1'b1;
        ld_addr  = a;
        ld_type  = t;
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d, input memop_data_type_e t);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        st_type  = t;
        tick();
        st_valid = 1'b0;
    endtask

    task automatic check_head(input string tag, input logic [31:0] a, input logic [31:0] d,
                              input memop_data_type_e t);
        check({tag, " flush"}, 32'(sb_flush), 32'd1);
        check({tag, " addr"}, sb_addr, a);
        check({tag, " data"}, sb_data_flush, d);
        check({tag, " type"}, 32'(sb_type_flush), 32'(t));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " empty"}, 32'(sb_empty), 32'd1);
        check({tag, " full"}, 32'(sb_full), 32'd0);
        check({tag, " flush"}, 32'(sb_flush), 32'd0);
        check({tag, " addr"}, sb_addr, 32'd0);
        check({tag, " data_flush"}, sb_data_flush, 32'd0);
        check({tag, " type_flush"}, 32'(sb_type_flush), 32'(BYTE));
        check_ld(tag, 1'b0, 1'b0, 32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        st_valid   = 1'b0;
        st_addr    = '0;
        st_data    = '0;
        st_type    = BYTE;
        ld_valid   = 1'b0;
        ld_addr    = '0;
        ld_type    = BYTE;
        cache_free = 1'b1;
        #1;
        check_reset_outputs("reset");
        tick();
        rst        = 1'b0;
        cache_free = 1'b0;
        tick();

        // Store pushed this cycle is not yet visible to a load
        st_valid = 1'b1;
        st_addr  = 32'h100;
        st_data  = 32'hDEADBEEF;
        st_type  = WORD;
        load(32'h100, WORD);
        check_ld("same-cycle push", 1'b0, 1'b0, 32'd0);
        tick();
        st_valid = 1'b0;
        check("one entry empty", 32'(sb_empty), 32'd0);
        check("one entry full", 32'(sb_full), 32'd0);
        check("no pop while cache busy", 32'(sb_flush), 32'd0);

        load(32'h102, HALF);
        expect_fwd("half 0x102", 32'h0000DEAD);
        load(32'h103, BYTE);
        expect_fwd("byte 0x103", 32'h000000DE);
        load(32'h0FC, WORD);
        check_ld("below range", 1'b0, 1'b0, 32'd0);
        load(32'h104, BYTE);
        check_ld("just above range", 1'b0, 1'b0, 32'd0);
        ld_valid = 1'b0;
        load(32'h100, WORD);
        ld_valid = 1'b0;
        #1;
        check_ld("ld_valid low", 1'b0, 1'b0, 32'd0);

        // Partial overlap stalls the load in both builds
        push(32'h104, 32'h00000055, BYTE);
        load(32'h104, WORD);
        check_ld("partial 0x104", 1'b0, 1'b1, 32'd0);
        load(32'h104, BYTE);
        expect_fwd("byte 0x104", 32'h00000055);
        ld_valid = 1'b0;

        // Drain in FIFO order
        cache_free = 1'b1;
        #1;
        check_head("pop0", 32'h100, 32'hDEADBEEF, WORD);
        tick();
        check_head("pop1", 32'h104, 32'h00000055, BYTE);
        tick();
        check("drained empty", 32'(sb_empty), 32'd1);
        check("no pop when empty", 32'(sb_flush), 32'd0);
        cache_free = 1'b0;

        // Youngest of two same-address stores wins
        push(32'h200, 32'h11111111, WORD);
        push(32'h200, 32'h22222222, WORD);
        load(32'h200, WORD);
        expect_fwd("youngest", 32'h22222222);
        ld_valid   = 1'b0;
        cache_free = 1'b1;
        #1;
        check_head("pop older", 32'h200, 32'h11111111, WORD);
        tick();
        check_head("pop younger", 32'h200, 32'h22222222, WORD);
        tick();
        check("drained again", 32'(sb_empty), 32'd1);
        cache_free = 1'b0;

        // Fill to capacity, then a dropped push
        for (int i = 0; i < 4; i++) begin
            push(32'h300 + 32'(4 * i), 32'hA0 + 32'(i), WORD);
        end
        check("full after 4", 32'(sb_full), 32'd1);
        check("not empty when full", 32'(sb_empty), 32'd0);
        push(32'h400, 32'h00000BAD, WORD);
        check("full after drop", 32'(sb_full), 32'd1);
        load(32'h400, WORD);
        check_ld("dropped store", 1'b0, 1'b0, 32'd0);

        // Full buffer, push and pop on the same edge; popping entry still visible
        cache_free = 1'b1;
        st_valid   = 1'b1;
        st_addr    = 32'h500;
        st_data    = 32'h000000C0;
        st_type    = WORD;
        load(32'h300, WORD);
        check_head("full pop0", 32'h300, 32'hA0, WORD);
        expect_fwd("popping entry", 32'h000000A0);
        tick();
        st_valid = 1'b0;
        ld_valid = 1'b0;
        check("count stays 4", 32'(sb_full), 32'd1);
        for (int i = 1; i < 4; i++) begin
            check_head($sformatf("full pop%0d", i), 32'h300 + 32'(4 * i), 32'hA0 + 32'(i), WORD);
            tick();
        end
        check_head("wrapped entry", 32'h500, 32'h000000C0, WORD);
        tick();
        check("empty after wrap", 32'(sb_empty), 32'd1);
        cache_free = 1'b0;

        // Reset in the middle of a pop with two entries buffered
        push(32'h600, 32'h00000066, WORD);
        push(32'h604, 32'h00000077, WORD);
        cache_free = 1'b1;
        load(32'h600, WORD);
        check("pre-reset flush", 32'(sb_flush), 32'd1);
        expect_fwd("pre-reset load", 32'h00000066);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("mid-pop reset");
        tick();
        check_reset_outputs("held reset");
        rst = 1'b0;
        tick();
        check_ld("after reset", 1'b0, 1'b0, 32'd0);
        check("after reset empty", 32'(sb_empty), 32'd1);
        ld_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
